// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked execute-stage ALU with a serial shifter; define MULTICYCLE_ALU_FAST_SHIFT_EN for a one-cycle barrel shifter
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Illegal
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] res, res_n, alu;
  logic ill, ill_n, legal;
  logic [SHW-1:0] n;
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
  logic [SHW-1:0] cnt, cnt_n;
  logic [1:0] sop, sop_n;
  logic shift;
  assign shift = ALUControl == 4'b0100 || ALUControl == 4'b1000 || ALUControl == 4'b1001;
`endif
  assign n = SrcB[SHW-1:0];
  assign legal = ALUControl <= 4'b1001;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign ALUResult = res;
  assign Zero = res == '0;
  assign Illegal = ill;
  always_comb begin
    alu = '0;
    case (ALUControl)
      4'b0000: alu = SrcA + SrcB;
      4'b0001: alu = SrcA - SrcB;
      4'b0010: alu = SrcA & SrcB;
      4'b0011: alu = SrcA | SrcB;
      4'b0101: alu = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      4'b0110: alu = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
      4'b0111: alu = SrcA ^ SrcB;
`ifdef MULTICYCLE_ALU_FAST_SHIFT_EN
      4'b0100: alu = SrcA << n;
      4'b1000: alu = SrcA >> n;
      4'b1001: alu = $signed(SrcA) >>> n;
`else
      // serial shifts start from SrcA, which is also the result when N = 0
      4'b0100, 4'b1000, 4'b1001: alu = SrcA;
`endif
      default: alu = '0;
    endcase
  end
  always_comb begin
    state_n = state;
    res_n = res;
    ill_n = ill;
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
    cnt_n = cnt;
    sop_n = sop;
`endif
    case (state)
      IDLE: if (in_valid) begin
        res_n = legal ? alu : '0;
        ill_n = !legal;
        state_n = DONE;
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
        cnt_n = n;
        sop_n = {ALUControl[3], ALUControl[0]};
        if (legal && shift && n != '0) state_n = SHIFT;
`endif
      end
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
      SHIFT: begin
        res_n = sop[1] ? (sop[0] ? WIDTH'($signed(res) >>> 1) : res >> 1) : res << 1;
        cnt_n = cnt - 1'b1;
        if (cnt == SHW'(1)) state_n = DONE;
      end
`endif
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      res <= '0;
      ill <= 1'b0;
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
      cnt <= '0;
      sop <= '0;
`endif
    end else begin
      state <= state_n;
      res <= res_n;
      ill <= ill_n;
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
      cnt <= cnt_n;
      sop <= sop_n;
`endif
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: table-driven vectors plus hold and mid-operation reset sequences
module tb_multicycle_alu;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [3:0] ALUControl = 0;
  logic [31:0] SrcA = 0, SrcB = 0, ALUResult;
  logic in_ready, out_valid, Zero, Illegal;
  int checks = 0, failures = 0;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic [31:0] a, b, res;
    logic ill;
    int lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output logic ill, output int lat);
    @(negedge clk);
    chk("in_ready_before", {31'b0, in_ready}, 32'd1);
    in_valid = 1; ALUControl = code; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    in_valid = 0; SrcA = 32'hDEADBEEF; SrcB = 32'h12345678; ALUControl = 4'b0000;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = ALUResult; z = Zero; ill = Illegal;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("in_ready_after", {31'b0, in_ready}, 32'd1);
  endtask

  vec_t v[19];
  logic [31:0] r, held;
  logic z, il;
  int lat, el;

  initial begin
    v[0]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1};
    v[1]  = '{4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1};
    v[2]  = '{4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1};
    v[3]  = '{4'b0011, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1};
    v[4]  = '{4'b0111, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1};
    v[5]  = '{4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1};
    v[6]  = '{4'b0110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1};
    v[7]  = '{4'b0101, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1};
    v[8]  = '{4'b0110, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1};
    v[9]  = '{4'b1001, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 32};
    v[10] = '{4'b1000, 32'h80000000, 32'd31,       32'h00000001, 1'b0, 32};
    v[11] = '{4'b0100, 32'h00000001, 32'd0,        32'h00000001, 1'b0, 1};
    v[12] = '{4'b0100, 32'h00000003, 32'hFFFFFFE4, 32'h00000030, 1'b0, 5};
    v[13] = '{4'b1001, 32'hF0000000, 32'h00000021, 32'hF8000000, 1'b0, 2};
    v[14] = '{4'b1001, 32'h40000000, 32'd2,        32'h10000000, 1'b0, 3};
    v[15] = '{4'b1111, 32'h12345678, 32'h11111111, 32'h00000000, 1'b1, 1};
    v[16] = '{4'b1010, 32'h12345678, 32'h11111111, 32'h00000000, 1'b1, 1};
    v[17] = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1};
    v[18] = '{4'b0001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1};

    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_zero", {31'b0, Zero}, 32'd1);
    chk("rst_illegal", {31'b0, Illegal}, 32'd0);

    foreach (v[i]) begin
      run_op(v[i].code, v[i].a, v[i].b, r, z, il, lat);
`ifdef MULTICYCLE_ALU_FAST_SHIFT_EN
      el = 1;
`else
      el = v[i].lat;
`endif
      chk($sformatf("v%0d_result", i), r, v[i].res);
      chk($sformatf("v%0d_zero", i), {31'b0, z}, {31'b0, v[i].res == 0});
      chk($sformatf("v%0d_illegal", i), {31'b0, il}, {31'b0, v[i].ill});
      chk($sformatf("v%0d_latency", i), lat, el);
    end

    // XOR held for 10 cycles while in_valid pulses must be ignored
    @(negedge clk);
    in_valid = 1; ALUControl = 4'b0111; SrcA = 32'h0F0F0F0F; SrcB = 32'h00FF00FF;
    @(posedge clk); #1;
    in_valid = 0;
    chk("hold_valid0", {31'b0, out_valid}, 32'd1);
    held = 32'h0FF00FF0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = c[0]; ALUControl = 4'b0000; SrcA = 32'd100; SrcB = 32'd200;
      @(posedge clk); #1;
      if (c == 0 || c == 9) begin
        chk($sformatf("hold%0d_valid", c), {31'b0, out_valid}, 32'd1);
        chk($sformatf("hold%0d_result", c), ALUResult, held);
        chk($sformatf("hold%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
      end else if (!out_valid || ALUResult !== held || in_ready) begin
        chk($sformatf("hold%0d_stable", c), {ALUResult[29:0], out_valid, in_ready}, {held[29:0], 2'b10});
      end
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("hold_release_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("hold_no_extra_accept", {31'b0, out_valid}, 32'd0);

    // reset on the third cycle of an SLL by 20
    @(negedge clk);
    in_valid = 1; ALUControl = 4'b0100; SrcA = 32'h00000001; SrcB = 32'd20;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_result", ALUResult, 32'd0);
    chk("mid_rst_zero", {31'b0, Zero}, 32'd1);
    chk("mid_rst_illegal", {31'b0, Illegal}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_stays_idle", {31'b0, out_valid}, 32'd0);
    run_op(4'b0000, 32'd2, 32'd3, r, z, il, lat);
    chk("post_rst_add", r, 32'd5);
    chk("post_rst_lat", lat, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
